// File: rtl/sobel_out_buffer_if.sv
// Bundles the producer write port and the read-out valid/ready stream of sobel_out_buffer.
// "master" is the buffer's view of the bundle; "slave" is the environment's view.
interface sobel_out_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_last;

  modport master (
    input  wr_en, wr_addr, wr_data, m_ready,
    output m_valid, m_data, m_addr, m_last
  );

  modport slave (
    output wr_en, wr_addr, wr_data, m_ready,
    input  m_valid, m_data, m_addr, m_last
  );
endinterface

// File: rtl/sobel_out_buffer.sv
// Frame capture RAM for the sobel output stream.
// Read-out uses a registered RAM read followed by a 2-entry skid FIFO.
module sobel_out_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               frame_done_i,
  sobel_out_buffer_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               wr_err_o
);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  wr_err_q, wr_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] ram_dout_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  fifo_wr_idx_q, fifo_wr_idx_d;
  logic                  fifo_rd_idx_q, fifo_rd_idx_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic          in_range;
  logic          ram_we;
  logic          rd_issue;
  logic          pop;
  logic [CW-1:0] addr_p1;
  logic [CW-1:0] count_w;
  logic [2:0]    slots_used;

  assign in_range   = {1'b0, bus.wr_addr} < DEPTH_C;
  assign addr_p1    = {1'b0, bus.wr_addr} + CW'(1);
  assign pop        = bus.m_valid && bus.m_ready;
  // Entries occupied next cycle if nothing new is issued; a read is only issued when it is sure to fit.
  assign slots_used = 3'(fifo_cnt_q) + 3'(rd_vld_q) - 3'(pop);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_err_d  = wr_err_q;
    ram_we    = 1'b0;
    rd_issue  = 1'b0;
    count_w   = count_q;
    rd_addr_d = rd_ptr_q[ADDR_WIDTH-1:0];
    rd_last_d = (rd_ptr_q == count_q - CW'(1));
    if (bus.wr_en && in_range && (addr_p1 > count_q)) begin
      count_w = addr_p1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CAPTURE;
          count_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (bus.wr_en) begin
          if (in_range) begin
            ram_we  = 1'b1;
            count_d = count_w;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        if (frame_done_i) begin
          rd_ptr_d = '0;
          state_d  = (count_w == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((rd_ptr_q < count_q) && (slots_used < 3'd2)) begin
          rd_issue = 1'b1;
          rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (pop && fifo_last_q[fifo_rd_idx_q]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_i) begin
          state_d  = ST_CAPTURE;
          count_d  = '0;
          wr_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stray write wins over the clear from a simultaneous restart so it is never lost.
    if (bus.wr_en && (state_q != ST_CAPTURE)) begin
      wr_err_d = 1'b1;
    end
    rd_vld_d = rd_issue;
    busy_d   = (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
  end

  always_comb begin
    fifo_data_d   = fifo_data_q;
    fifo_addr_d   = fifo_addr_q;
    fifo_last_d   = fifo_last_q;
    fifo_wr_idx_d = fifo_wr_idx_q;
    fifo_rd_idx_d = fifo_rd_idx_q;
    if (rd_vld_q) begin
      fifo_data_d[fifo_wr_idx_q] = ram_dout_q;
      fifo_addr_d[fifo_wr_idx_q] = rd_addr_q;
      fifo_last_d[fifo_wr_idx_q] = rd_last_q;
      fifo_wr_idx_d              = ~fifo_wr_idx_q;
    end
    if (pop) begin
      fifo_rd_idx_d = ~fifo_rd_idx_q;
    end
    fifo_cnt_d = fifo_cnt_q + 2'(rd_vld_q) - 2'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      ram[bus.wr_addr[RAM_AW-1:0]] <= bus.wr_data;
    end
    if (rd_issue) begin
      ram_dout_q <= ram[rd_ptr_q[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_addr_q     <= '0;
      fifo_data_q   <= '{default: '0};
      fifo_addr_q   <= '{default: '0};
      fifo_last_q   <= '0;
      fifo_wr_idx_q <= 1'b0;
      fifo_rd_idx_q <= 1'b0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_err_q      <= wr_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_vld_q      <= rd_vld_d;
      rd_last_q     <= rd_last_d;
      rd_addr_q     <= rd_addr_d;
      fifo_data_q   <= fifo_data_d;
      fifo_addr_q   <= fifo_addr_d;
      fifo_last_q   <= fifo_last_d;
      fifo_wr_idx_q <= fifo_wr_idx_d;
      fifo_rd_idx_q <= fifo_rd_idx_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  assign bus.m_valid = (fifo_cnt_q != 2'd0);
  assign bus.m_data  = fifo_data_q[fifo_rd_idx_q];
  assign bus.m_addr  = fifo_addr_q[fifo_rd_idx_q];
  assign bus.m_last  = fifo_last_q[fifo_rd_idx_q];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wr_err_o    = wr_err_q;
endmodule

// File: tb/tb_sobel_out_buffer.sv
// Directed plus randomized bench for sobel_out_buffer against a frame-level reference model.
module tb_sobel_out_buffer;
  localparam int DW    = 8;
  localparam int AW    = 13;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic frame_done = 1'b0;
  logic busy, done, wr_err;

  sobel_out_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sobel_out_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .frame_done_i (frame_done),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .wr_err_o     (wr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame memory, highest written address + 1, sticky error, capture window.
  logic [DW-1:0] mem_m [DEPTH];
  int count_m = 0;
  bit err_m = 1'b0;
  bit cap_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input int addr, input int data);
    if (cap_m && addr < DEPTH) begin
      mem_m[addr] = DW'(data);
      if (addr + 1 > count_m) count_m = addr + 1;
    end else begin
      err_m = 1'b1;
    end
  endfunction

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    cap_m = 1'b1;
    count_m = 0;
    err_m = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_err", wr_err, err_m);
  endtask

  task automatic wr(input int addr, input int data, input bit fdone);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = DW'(data);
    frame_done  = fdone;
    tick();
    bus.wr_en  = 1'b0;
    frame_done = 1'b0;
    model_write(addr, data);
    if (fdone) cap_m = 1'b0;
  endtask

  task automatic end_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    cap_m = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode, input bit wr_noise, input int abort_after);
    int  idx = 0;
    int  cyc = 0;
    bit  prev_stall = 1'b0;
    bit  rdy;
    bit  vld_now;
    check("pre_valid_e0", bus.m_valid, 0);
    tick();
    check("pre_valid_e1", bus.m_valid, 0);
    tick();
    check("first_valid_e2", bus.m_valid, 1);
    while (idx < count_m && cyc < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.m_ready = rdy;
      if (wr_noise) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, 63));
        bus.wr_data = DW'($urandom_range(0, 255));
        err_m = 1'b1;
      end
      vld_now = bus.m_valid;
      if (prev_stall || mode == 0) check("valid_held", bus.m_valid, 1);
      if (vld_now) begin
        check("beat_data", bus.m_data, mem_m[idx]);
        check("beat_addr", bus.m_addr, idx);
        check("beat_last", bus.m_last, (idx == count_m - 1));
      end
      tick();
      if (vld_now && rdy) idx++;
      prev_stall = vld_now && !rdy;
      cyc++;
      if (abort_after != 0 && idx == abort_after) break;
    end
    bus.wr_en   = 1'b0;
    bus.m_ready = 1'b0;
    if (abort_after == 0) begin
      check("beat_count", idx, count_m);
      check("post_valid", bus.m_valid, 0);
      check("post_done", done, 1);
      check("post_busy", busy, 0);
      check("post_err", wr_err, err_m);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.m_ready = 1'b0;

    // Reset held for five edges.
    repeat (5) tick();
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", wr_err, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Basic capture and drain.
    start_frame();
    for (int a = 0; a < 16; a++) wr(a, 8'h10 + a, 1'b0);
    end_frame();
    drain(0, 1'b0, 0);

    // Out-of-order writes with an overwrite.
    start_frame();
    wr(3, 8'hAA, 1'b0);
    wr(0, 8'h11, 1'b0);
    wr(3, 8'hBB, 1'b0);
    wr(1, 8'h22, 1'b0);
    wr(2, 8'h33, 1'b0);
    end_frame();
    drain(0, 1'b0, 0);

    // Backpressure on an 8-pixel random frame.
    start_frame();
    for (int a = 0; a < 8; a++) wr(a, $urandom_range(0, 255), 1'b0);
    end_frame();
    drain(1, 1'b0, 0);

    // Empty frame goes straight to DONE.
    start_frame();
    end_frame();
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    check("empty_valid", bus.m_valid, 0);
    tick();
    tick();
    check("empty_valid_later", bus.m_valid, 0);

    // Only write coincides with frame_done.
    start_frame();
    wr(0, 8'h5A, 1'b1);
    drain(0, 1'b0, 0);

    // Out-of-range write, then writes during drain.
    start_frame();
    wr(4096, 8'hEE, 1'b0);
    check("oob_err", wr_err, 1);
    check("oob_busy", busy, 1);
    for (int a = 0; a < 6; a++) wr(a, $urandom_range(0, 255), 1'b0);
    end_frame();
    drain(2, 1'b1, 0);

    // Random scattered frames with random backpressure.
    for (int f = 0; f < 3; f++) begin
      start_frame();
      n = $urandom_range(1, 16);
      for (int k = 0; k < 2 * n; k++) wr($urandom_range(0, n - 1), $urandom_range(0, 255), 1'b0);
      wr(n - 1, $urandom_range(0, 255), 1'b1);
      drain(2, 1'b0, 0);
    end

    // Reset after the tenth beat of a 64-pixel frame.
    start_frame();
    for (int a = 0; a < 64; a++) wr(a, $urandom_range(0, 255), 1'b0);
    end_frame();
    drain(0, 1'b0, 10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    err_m = 1'b0;
    cap_m = 1'b0;
    count_m = 0;
    check("abort_valid", bus.m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", wr_err, 0);

    start_frame();
    for (int a = 0; a < 4; a++) wr(a, $urandom_range(0, 255), 1'b0);
    end_frame();
    drain(0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
